mod_reduce: RTL and testbench

MOD_REDUCE -- requirements
Module: mod_reduce

---
 rtl/mod_pkg.sv | 34 +++
 rtl/mod_reduce_if.sv | 37 +++
 rtl/mod_cmp_sub.sv | 29 ++
 rtl/mod_reduce.sv | 168 ++++++++++++++++
 tb/tb_mod_reduce.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mod_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : mod_pkg                                                   |
// | Description: Shared types and constants for the modular reduction      |
// |              block: FSM state encoding, default operand widths and     |
// |              the shift-counter width helper.                           |
// | Ports      : none                                                      |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package mod_pkg;

  localparam int DW_DEFAULT = 256;
  localparam int MW_DEFAULT = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_REDUCE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bits needed to hold values 0..value-1; called as clog2(DW+1) so the
  // shift counter can reach DW.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_reduce_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface  : mod_reduce_if                                             |
// | Description: Request/result bundle of the modular reduction block.     |
// | Signals    : start, abort, y[DW], x[MW]  - requester to block          |
// |              ready, done, r[MW], err     - block to requester          |
// |              q[DW] (MOD_REDUCE_QUOTIENT_EN only) - quotient            |
// | Modports   : master (requester), slave (mod_reduce)                    |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
interface mod_reduce_if
  import mod_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int MW = MW_DEFAULT
) ();

  logic          start;
  logic          abort;
  logic [DW-1:0] y;
  logic [MW-1:0] x;
  logic          ready;
  logic          done;
  logic [MW-1:0] r;
  logic          err;
`ifdef MOD_REDUCE_QUOTIENT_EN
  logic [DW-1:0] q;

  modport master (output start, abort, y, x, input ready, done, r, err, q);
  modport slave  (input start, abort, y, x, output ready, done, r, err, q);
`else
  modport master (output start, abort, y, x, input ready, done, r, err);
  modport slave  (input start, abort, y, x, output ready, done, r, err);
`endif

endinterface
`default_nettype wire

// File: rtl/mod_cmp_sub.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : mod_cmp_sub                                               |
// | Description: Single-subtractor compare/subtract. ge = (a >= b) is the  |
// |              inverted borrow of a - b, so one carry chain gives both.  |
// | Ports      : a, b [W]  operands                                        |
// |              ge        a >= b (unsigned)                               |
// |              diff [W]  a - b (meaningful when ge=1)                    |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module mod_cmp_sub
  import mod_pkg::*;
#(
  parameter int W = DW_DEFAULT + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ge,
  output logic [W-1:0] diff
);

  logic [W:0] full;

  assign full = {1'b0, a} - {1'b0, b};
  assign ge   = ~full[W];
  assign diff = full[W-1:0];

endmodule
`default_nettype wire

// File: rtl/mod_reduce.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : mod_reduce                                                |
// | Description: Computes r = y mod x by shift-and-subtract. ALIGN doubles |
// |              the modulus P until P >= Yr, counting shifts in K; REDUCE |
// |              then subtracts and halves P for K+1 cycles.               |
// | Ports      : clk     clock, rising edge                                |
// |              rst_n   asynchronous active-low reset                     |
// |              bus     mod_reduce_if.slave (start/abort/y/x in,          |
// |                      ready/done/r/err[/q] out)                         |
// | Config     : MOD_REDUCE_QUOTIENT_EN adds quotient output q             |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module mod_reduce
  import mod_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int MW = MW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_reduce_if.slave   bus
);

  localparam int PW = DW + 1;
  localparam int KW = clog2(DW + 1);

  state_e        state_q, state_d;
  logic [DW-1:0] yr_q, yr_d;
  logic [PW-1:0] p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic [MW-1:0] r_q, r_d;
  logic          err_q, err_d;
`ifdef MOD_REDUCE_QUOTIENT_EN
  logic [DW-1:0] q_q, q_d;
`endif

  logic [PW-1:0] cmp_a, cmp_b, cmp_diff;
  logic          cmp_ge;
  logic          diff_msb_unused;

  // ALIGN asks "P >= Yr?", REDUCE asks "Yr >= P?" - one shared subtractor.
  assign cmp_a = (state_q == ST_ALIGN) ? p_q : {1'b0, yr_q};
  assign cmp_b = (state_q == ST_ALIGN) ? {1'b0, yr_q} : p_q;

  mod_cmp_sub #(.W(PW)) u_cmp_sub (
    .a    (cmp_a),
    .b    (cmp_b),
    .ge   (cmp_ge),
    .diff (cmp_diff)
  );

  // A taken subtract in REDUCE always has Yr >= P, so the result fits DW bits.
  assign diff_msb_unused = cmp_diff[PW-1];

  always_comb begin
    state_d = state_q;
    yr_d    = yr_q;
    p_d     = p_q;
    k_d     = k_q;
    r_d     = r_q;
    err_d   = err_q;
`ifdef MOD_REDUCE_QUOTIENT_EN
    q_d     = q_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ALIGN;
          yr_d    = bus.y;
          p_d     = {{(PW-MW){1'b0}}, bus.x};
          k_d     = '0;
          r_d     = '0;
          err_d   = 1'b0;
`ifdef MOD_REDUCE_QUOTIENT_EN
          q_d     = '0;
`endif
        end
      end
      ST_ALIGN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          k_d     = '0;
          r_d     = '0;
          err_d   = 1'b0;
`ifdef MOD_REDUCE_QUOTIENT_EN
          q_d     = '0;
`endif
        end else if (p_q == '0) begin
          // Zero modulus would shift forever; flag it and finish.
          state_d = ST_DONE;
          err_d   = 1'b1;
          r_d     = '0;
        end else if (!cmp_ge) begin
          p_d = p_q << 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          k_d     = '0;
          r_d     = '0;
          err_d   = 1'b0;
`ifdef MOD_REDUCE_QUOTIENT_EN
          q_d     = '0;
`endif
        end else begin
          if (cmp_ge) begin
            yr_d = cmp_diff[DW-1:0];
          end
          p_d = p_q >> 1;
`ifdef MOD_REDUCE_QUOTIENT_EN
          q_d = {q_q[DW-2:0], cmp_ge};
`endif
          if (k_q == '0) begin
            state_d = ST_DONE;
            r_d     = cmp_ge ? cmp_diff[MW-1:0] : yr_q[MW-1:0];
          end else begin
            k_d = k_q - KW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      yr_q    <= '0;
      p_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
`ifdef MOD_REDUCE_QUOTIENT_EN
      q_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      yr_q    <= yr_d;
      p_q     <= p_d;
      k_q     <= k_d;
      r_q     <= r_d;
      err_q   <= err_d;
`ifdef MOD_REDUCE_QUOTIENT_EN
      q_q     <= q_d;
`endif
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.r     = r_q;
  assign bus.err   = err_q;
`ifdef MOD_REDUCE_QUOTIENT_EN
  assign bus.q     = q_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_reduce.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_mod_reduce                                             |
// | Description: Directed bench for mod_reduce at DW=32, MW=16: reset      |
// |              state, reduction results and latency, zero modulus,       |
// |              extreme shift count, abort, mid-operation reset, start    |
// |              held through done, plus random pairs vs y % x.            |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_mod_reduce;

  localparam int DW     = 32;
  localparam int MW     = 16;
  localparam int BUDGET = 2 * DW + 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mod_reduce_if #(.DW(DW), .MW(MW)) bus ();

  mod_reduce #(.DW(DW), .MW(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int calc_k(input logic [DW-1:0] yv, input logic [MW-1:0] xv);
    logic [63:0] p;
    int k;
    p = 64'(xv);
    k = 0;
    while (p < 64'(yv)) begin
      p = p << 1;
      k++;
    end
    return k;
  endfunction

  // One full operation; done is expected in cycle elat after the accept edge.
  task automatic run_op(input string tag, input logic [DW-1:0] yv, input logic [MW-1:0] xv,
                        input logic [MW-1:0] er, input logic ee, input logic [DW-1:0] eq,
                        input int elat, input bit hold, input bit abort_done);
    int n;
    bit seen;
    @(negedge clk);
    check($sformatf("%s ready_idle", tag), 64'(bus.ready), 64'd1);
    bus.start = 1'b1;
    bus.y     = yv;
    bus.x     = xv;
    @(negedge clk);
    n = 1;
    seen = 1'b0;
    if (!hold) bus.start = 1'b0;
    bus.y = ~yv;
    bus.x = ~xv;
    check($sformatf("%s ready_busy", tag), 64'(bus.ready), 64'd0);
    while (!seen && n <= BUDGET) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check($sformatf("%s done_seen", tag), 64'(seen), 64'd1);
    check($sformatf("%s latency", tag), 64'(n), 64'(elat));
    check($sformatf("%s r", tag), 64'(bus.r), 64'(er));
    check($sformatf("%s err", tag), 64'(bus.err), 64'(ee));
`ifdef MOD_REDUCE_QUOTIENT_EN
    check($sformatf("%s q", tag), 64'(bus.q), 64'(eq));
`endif
    if (abort_done) bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check($sformatf("%s done_pulse", tag), 64'(bus.done), 64'd0);
    check($sformatf("%s ready_after", tag), 64'(bus.ready), 64'd1);
    check($sformatf("%s r_held", tag), 64'(bus.r), 64'(er));
    check($sformatf("%s err_held", tag), 64'(bus.err), 64'(ee));
`ifdef MOD_REDUCE_QUOTIENT_EN
    check($sformatf("%s q_held", tag), 64'(bus.q), 64'(eq));
`endif
  endtask

  task automatic run_random(input int idx, input logic [DW-1:0] yv, input logic [MW-1:0] xv);
    if (xv == '0)
      run_op($sformatf("rnd%0d", idx), yv, xv, '0, 1'b1, '0, 2, 1'b0, 1'b0);
    else
      run_op($sformatf("rnd%0d", idx), yv, xv, MW'(yv % DW'(xv)), 1'b0, yv / DW'(xv),
             2 * calc_k(yv, xv) + 3, 1'b0, 1'b0);
  endtask

  initial begin
    int dcount;
    logic [DW-1:0] ry;
    logic [MW-1:0] rx;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.y     = '0;
    bus.x     = '0;

    // Reset state
    #3;
    check("rst ready", 64'(bus.ready), 64'd1);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst r", 64'(bus.r), 64'd0);
    check("rst err", 64'(bus.err), 64'd0);
`ifdef MOD_REDUCE_QUOTIENT_EN
    check("rst q", 64'(bus.q), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: tag, y, x, r, err, q, done cycle, hold start, abort at done
    run_op("basic",   32'd100,        16'd7,      16'd2,  1'b0, 32'd14,        11, 1'b0, 1'b0);
    run_op("y_lt_x",  32'd5,          16'd9,      16'd5,  1'b0, 32'd0,          3, 1'b0, 1'b0);
    run_op("x_zero",  32'd42,         16'd0,      16'd0,  1'b1, 32'd0,          2, 1'b0, 1'b0);
    run_op("y_eq_x",  32'd7,          16'd7,      16'd0,  1'b0, 32'd1,          3, 1'b0, 1'b0);
    run_op("y_zero",  32'd0,          16'd5,      16'd0,  1'b0, 32'd0,          3, 1'b0, 1'b0);
    run_op("k4",      32'd255,        16'd16,     16'd15, 1'b0, 32'd15,        11, 1'b0, 1'b0);
    run_op("kmax",    32'hFFFF_FFFF,  16'd1,      16'd0,  1'b0, 32'hFFFF_FFFF, 67, 1'b0, 1'b0);
    run_op("xmax",    32'hFFFF_FFFF,  16'hFFFF,   16'd0,  1'b0, 32'h0001_0001, 37, 1'b0, 1'b0);
    run_op("hold",    32'd100,        16'd7,      16'd2,  1'b0, 32'd14,        11, 1'b1, 1'b0);
    run_op("abrt_dn", 32'd255,        16'd16,     16'd15, 1'b0, 32'd15,        11, 1'b0, 1'b1);

    // Abort three cycles into an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.y     = 32'd100;
    bus.x     = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort ready", 64'(bus.ready), 64'd1);
    check("abort r", 64'(bus.r), 64'd0);
    check("abort err", 64'(bus.err), 64'd0);
    dcount = 0;
    repeat (15) begin
      if (bus.done === 1'b1) dcount++;
      @(negedge clk);
    end
    check("abort no_done", 64'(dcount), 64'd0);
    run_op("restart", 32'd100, 16'd7, 16'd2, 1'b0, 32'd14, 11, 1'b0, 1'b0);

    // Reset in the middle of REDUCE (cycles 6..10 for 100 mod 7)
    @(negedge clk);
    bus.start = 1'b1;
    bus.y     = 32'd100;
    bus.x     = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst ready", 64'(bus.ready), 64'd1);
    check("midrst done", 64'(bus.done), 64'd0);
    check("midrst r", 64'(bus.r), 64'd0);
    check("midrst err", 64'(bus.err), 64'd0);
`ifdef MOD_REDUCE_QUOTIENT_EN
    check("midrst q", 64'(bus.q), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'd100, 16'd7, 16'd2, 1'b0, 32'd14, 11, 1'b0, 1'b0);

    // Random pairs against y % x
    for (int i = 0; i < 100; i++) begin
      ry = $urandom;
      rx = MW'($urandom) >> $urandom_range(0, MW - 1);
      run_random(i, ry, rx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
